// File: rtl/simd_pkg.sv
// simd_pkg: shared types and encodings for the SIMD unpack datapath.
//   lane_mode_t    : lane width encoding (code 3 is reserved and treated as W32)
//   word_t         : 32-bit packed SIMD word, lane 0 in the LSBs
//   unpack_state_t : handshake FSM states of simd_unpack
//   lane_count()   : number of lanes carried by a word in a given mode
package simd_pkg;

    typedef enum logic [1:0] {
        MODE_W32  = 2'd0,
        MODE_W16  = 2'd1,
        MODE_W8   = 2'd2,
        MODE_RSVD = 2'd3
    } lane_mode_t;

    typedef logic [31:0] word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } unpack_state_t;

    function automatic logic [2:0] lane_count(input lane_mode_t mode);
        case (mode)
            MODE_W16: return 3'd2;
            MODE_W8:  return 3'd4;
            default:  return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_extract.sv
// simd_lane_extract: combinational lane selection and extension to 32 bits.
//   word [31:0] : packed SIMD word, lane 0 in the LSBs
//   mode [1:0]  : simd_pkg::lane_mode_t lane width (reserved code acts as W32)
//   idx  [1:0]  : lane index to extract
//   sext        : 1 = sign-extend 8/16-bit lanes, 0 = zero-extend
//   lane [31:0] : selected lane, extended to 32 bits
module simd_lane_extract
    import simd_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  mode,
    input  logic [1:0]  idx,
    input  logic        sext,
    output logic [31:0] lane
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = '0;
        byte_sel = '0;
        lane     = '0;
        case (lane_mode_t'(mode))
            MODE_W16: begin
                half_sel = idx[0] ? word[31:16] : word[15:0];
                lane     = {{16{sext & half_sel[15]}}, half_sel};
            end
            MODE_W8: begin
                case (idx)
                    2'd0:    byte_sel = word[7:0];
                    2'd1:    byte_sel = word[15:8];
                    2'd2:    byte_sel = word[23:16];
                    default: byte_sel = word[31:24];
                endcase
                lane = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            default: lane = word;
        endcase
    end

endmodule

// File: rtl/simd_unpack.sv
// simd_unpack: splits a packed SIMD word into its lanes, one lane per
// downstream transfer, with valid/ready handshakes on both sides.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_vld / in_rdy    : input word handshake
//   in_mode [1:0]      : lane width (simd_pkg::lane_mode_t)
//   in_signed          : sign-extend lanes (only with SIMD_UNPACK_SEXT_EN)
//   in_word [31:0]     : packed word, lane 0 in the LSBs
//   out_vld / out_rdy  : lane output handshake
//   out_lane [31:0]    : extracted lane, extended to 32 bits
//   out_idx [1:0]      : lane index of out_lane
//   out_last           : final lane of the current word
// Optional feature macro: SIMD_UNPACK_SEXT_EN (adds in_signed port).
module simd_unpack
    import simd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [1:0]  in_mode,
`ifdef SIMD_UNPACK_SEXT_EN
    input  logic        in_signed,
`endif
    input  logic [31:0] in_word,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_lane,
    output logic [1:0]  out_idx,
    output logic        out_last
);

    unpack_state_t state_q, state_d;
    word_t         word_q;
    lane_mode_t    mode_q;
    logic [1:0]    idx_q, idx_d;
    logic          sext_cur;
    logic [2:0]    last_idx;
    logic          in_xfer, out_xfer;

`ifdef SIMD_UNPACK_SEXT_EN
    logic          sext_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sext_q <= 1'b0;
        end else if (in_xfer) begin
            sext_q <= in_signed;
        end
    end

    assign sext_cur = sext_q;
`else
    assign sext_cur = 1'b0;
`endif

    assign last_idx = lane_count(mode_q) - 3'd1;
    assign out_vld  = (state_q == ST_EMIT);
    assign out_last = out_vld && ({1'b0, idx_q} == last_idx);
    // Ready when idle, or when the final lane leaves this cycle so the next
    // word can be loaded without a bubble.
    assign in_rdy   = !out_vld || (out_rdy && out_last);
    assign in_xfer  = in_vld && in_rdy;
    assign out_xfer = out_vld && out_rdy;
    assign out_idx  = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    state_d = ST_EMIT;
                    idx_d   = '0;
                end
            end
            ST_EMIT: begin
                if (out_xfer) begin
                    if (out_last) begin
                        idx_d   = '0;
                        state_d = in_xfer ? ST_EMIT : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Word is cleared on reset so out_lane reads zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            mode_q <= MODE_W32;
        end else if (in_xfer) begin
            word_q <= in_word;
            mode_q <= lane_mode_t'(in_mode);
        end
    end

    simd_lane_extract u_extract (
        .word (word_q),
        .mode (mode_q),
        .idx  (idx_q),
        .sext (sext_cur),
        .lane (out_lane)
    );

endmodule

// File: tb/tb_simd_unpack.sv
// tb_simd_unpack: self-checking bench for simd_unpack. A queue of expected
// beats is filled from each accepted word and drained by each lane transfer;
// directed sequences pin literal values on top of randomized traffic.
module tb_simd_unpack;

`ifdef SIMD_UNPACK_SEXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [1:0]  in_mode = 2'd0;
    logic        sgn_in = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] out_lane;
    logic [1:0]  out_idx;
    logic        out_last;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] lane;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t q[$];

    simd_unpack dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_mode  (in_mode),
`ifdef SIMD_UNPACK_SEXT_EN
        .in_signed(sgn_in),
`endif
        .in_word  (in_word),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_lane (out_lane),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    function automatic int unsigned lanes_of(input logic [1:0] mode);
        if (mode == 2'd1) return 2;
        if (mode == 2'd2) return 4;
        return 1;
    endfunction

    function automatic logic [31:0] model_lane(input logic [31:0] w, input logic [1:0] mode,
                                               input int unsigned i, input logic sgn);
        int unsigned width;
        logic [63:0] mask;
        logic [63:0] v;
        width = 32 / lanes_of(mode);
        mask  = (64'd1 << width) - 64'd1;
        v     = ({32'd0, w} >> (i * width)) & mask;
        if (sgn && width < 32 && v[width-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: one check set per cycle, then advance the model with
    // the transfers that the coming posedge will perform.
    initial begin
        forever begin
            logic exp_rdy;
            @(negedge clk);
            #1;
            if (!rst_n) begin
                q.delete();
                chk("rst_out_vld", out_vld, 0);
                chk("rst_out_lane", out_lane, 0);
                chk("rst_out_idx", out_idx, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_in_rdy", in_rdy, 1);
            end else begin
                exp_rdy = (q.size() == 0) || (out_rdy && q.size() == 1);
                chk("in_rdy", in_rdy, exp_rdy);
                chk("out_vld", out_vld, q.size() != 0);
                if (q.size() != 0) begin
                    chk("out_lane", out_lane, q[0].lane);
                    chk("out_idx", out_idx, q[0].idx);
                    chk("out_last", out_last, q[0].last);
                    if (out_rdy) void'(q.pop_front());
                end
                if (in_vld && exp_rdy) begin
                    for (int unsigned i = 0; i < lanes_of(in_mode); i++) begin
                        beat_t b;
                        b.lane = model_lane(in_word, in_mode, i, sgn_in & SEXT);
                        b.idx  = 2'(i);
                        b.last = (i == lanes_of(in_mode) - 1);
                        q.push_back(b);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w8_exp [4];

        // Pin the model against hand-computed values.
        chk("model_w8_l2", model_lane(32'h80FF7F01, 2'd2, 2, 1'b0), 32'h000000FF);
        chk("model_w8_l3s", model_lane(32'h80FF7F01, 2'd2, 3, 1'b1), 32'hFFFFFF80);
        chk("model_w16_l1s", model_lane(32'h80001234, 2'd1, 1, 1'b1), 32'hFFFF8000);
        chk("model_rsvd", model_lane(32'hA5A5A5A5, 2'd3, 0, 1'b1), 32'hA5A5A5A5);

        // Reset state before any clock edge.
        #3;
        chk("init_out_vld", out_vld, 0);
        chk("init_out_lane", out_lane, 0);
        chk("init_out_idx", out_idx, 0);
        chk("init_out_last", out_last, 0);
        chk("init_in_rdy", in_rdy, 1);

        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        repeat (2) @(negedge clk);

        // W8 word, lanes in ascending order.
        if (SEXT) w8_exp = '{32'h1, 32'h7F, 32'hFFFFFFFF, 32'hFFFFFF80};
        else      w8_exp = '{32'h1, 32'h7F, 32'hFF, 32'h80};
        in_vld = 1'b1; in_mode = 2'd2; in_word = 32'h80FF7F01; sgn_in = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_vld = 1'b0; in_word = $urandom; in_mode = 2'($urandom); sgn_in = 1'b0;
            end
            #2;
            chk("w8_vld", out_vld, 1);
            chk("w8_lane", out_lane, w8_exp[i]);
            chk("w8_idx", out_idx, 2'(i));
            chk("w8_last", out_last, i == 3);
        end
        @(negedge clk); #2;
        chk("w8_done", out_vld, 0);

        // W16 word with downstream stall.
        @(negedge clk);
        in_vld = 1'b1; in_mode = 2'd1; in_word = 32'h80001234; out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0; in_word = $urandom;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk("stall_lane", out_lane, 32'h00001234);
            chk("stall_idx", out_idx, 0);
            chk("stall_last", out_last, 0);
            chk("stall_in_rdy", in_rdy, 0);
        end
        @(negedge clk);
        out_rdy = 1'b1;
        #2;
        chk("stall_rel_lane", out_lane, 32'h00001234);
        @(negedge clk); #2;
        chk("w16_l1_lane", out_lane, 32'h00008000);
        chk("w16_l1_last", out_last, 1);
        @(negedge clk); #2;
        chk("w16_done", out_vld, 0);

        // Back-to-back W32 words.
        @(negedge clk);
        in_vld = 1'b1; in_mode = 2'd0; in_word = 32'hDEADBEEF;
        #2;
        chk("b2b_rdy0", in_rdy, 1);
        @(negedge clk);
        in_word = 32'h12345678;
        #2;
        chk("b2b_lane0", out_lane, 32'hDEADBEEF);
        chk("b2b_rdy1", in_rdy, 1);
        @(negedge clk);
        in_vld = 1'b0;
        #2;
        chk("b2b_vld1", out_vld, 1);
        chk("b2b_lane1", out_lane, 32'h12345678);
        chk("b2b_rdy2", in_rdy, 1);
        @(negedge clk); #2;
        chk("b2b_done", out_vld, 0);

        // Reserved mode behaves as W32.
        @(negedge clk);
        in_vld = 1'b1; in_mode = 2'd3; in_word = 32'hA5A5A5A5;
        @(negedge clk);
        in_vld = 1'b0;
        #2;
        chk("rsvd_vld", out_vld, 1);
        chk("rsvd_lane", out_lane, 32'hA5A5A5A5);
        chk("rsvd_idx", out_idx, 0);
        chk("rsvd_last", out_last, 1);

        // Asynchronous reset in the middle of a W8 word.
        @(negedge clk);
        in_vld = 1'b1; in_mode = 2'd2; in_word = $urandom;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("mid_pre_vld", out_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_lane", out_lane, 0);
        chk("mid_rst_idx", out_idx, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_rdy", in_rdy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk); #2;
            chk("post_rst_vld", out_vld, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rst_n   = (n != 400);
            in_vld  = 1'($urandom_range(0, 1));
            in_mode = 2'($urandom);
            in_word = $urandom;
            sgn_in  = 1'($urandom);
            out_rdy = ($urandom_range(0, 9) < 7);
        end

        @(negedge clk);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
